// File: rtl/muldiv_sequencer.sv
// Multicycle sequencer for signed MULT/DIV: radix-2 Booth multiply and restoring divide,
// with start/done handshake, Hi/Lo load strobes and divide-by-zero reporting.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             load_hi,
  output logic             load_lo,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             op_r;
  logic             dz_r;
  logic [2*WIDTH:0] acc;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   div_sh;
  logic [WIDTH-1:0] div_diff;
  logic             div_fits;

  // Booth add/sub is done one bit wider than the partial product so that
  // subtracting -2^(W-1) cannot overflow before the arithmetic shift.
  always_comb begin
    booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} + {a_r[WIDTH-1], a_r};
      2'b10:   booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]} - {a_r[WIDTH-1], a_r};
      default: booth_sum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    endcase
  end

  always_comb begin
    mag_b    = b_r[WIDTH-1] ? -b_r : b_r;
    div_sh   = {rem, quo[WIDTH-1]};
    div_fits = (div_sh >= {1'b0, mag_b});
    div_diff = div_sh[WIDTH-1:0] - mag_b;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      op_r     <= 1'b0;
      dz_r     <= 1'b0;
      acc      <= '0;
      rem      <= '0;
      quo      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      load_hi  <= 1'b0;
      load_lo  <= 1'b0;
      div_zero <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
    end else begin
      done     <= 1'b0;
      load_hi  <= 1'b0;
      load_lo  <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a_in;
            b_r  <= b_in;
            op_r <= op;
            cnt  <= '0;
            dz_r <= 1'b0;
            if (!op) begin
              acc   <= {{WIDTH{1'b0}}, b_in, 1'b0};
              busy  <= 1'b1;
              state <= MULT;
            end else if (b_in == '0) begin
              dz_r  <= 1'b1;
              state <= DONE;
            end else begin
              rem   <= '0;
              quo   <= a_in[WIDTH-1] ? -a_in : a_in;
              busy  <= 1'b1;
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc <= {booth_sum, acc[WIDTH:1]};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DIV: begin
          rem <= div_fits ? div_diff : div_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], div_fits};
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          quo   <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) ? -quo : quo;
          rem   <= a_r[WIDTH-1] ? -rem : rem;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (dz_r) begin
            div_zero <= 1'b1;
          end else begin
            load_hi <= 1'b1;
            load_lo <= 1'b1;
            hi_out  <= op_r ? rem : acc[2*WIDTH:WIDTH+1];
            lo_out  <= op_r ? quo : acc[WIDTH:1];
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: a driver pushes reference results computed with
// plain 64-bit signed arithmetic; a monitor pops and compares on every done pulse.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         op = 1'b0;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy, done, load_hi, load_lo, div_zero;
  logic [W-1:0] hi_out, lo_out;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .load_hi(load_hi), .load_lo(load_lo),
    .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           vectors = 0;
  int           miscompares = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t ref_model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic [W-1:0] prev_hi, input logic [W-1:0] prev_lo);
    exp_t   e;
    longint sa, sbv, p, q, r;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    e.dz = 1'b0;
    if (!o) begin
      p    = sa * sbv;
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.dz = 1'b1;
      e.hi = prev_hi;
      e.lo = prev_lo;
    end else begin
      q    = sa / sbv;
      r    = sa % sbv;
      e.hi = r[31:0];
      e.lo = q[31:0];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_done: got done=1 expected no pending op at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("hi_out", hi_out, mon_e.hi);
        check("lo_out", lo_out, mon_e.lo);
        check("div_zero", div_zero, mon_e.dz);
        check("load_hi", load_hi, !mon_e.dz);
        check("load_lo", load_lo, !mon_e.dz);
        check("busy_at_done", busy, 0);
      end
    end else if (load_hi || load_lo || div_zero) begin
      vectors++;
      miscompares++;
      $display("FAIL stray_pulse: got load_hi=%0b load_lo=%0b div_zero=%0b expected 0 without done",
               load_hi, load_lo, div_zero);
    end
  end

  task automatic do_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit inject, input int abort_at);
    exp_t e;
    int   exp_lat, exp_busy, lat, busy_cnt;
    bit   seen, aborted;
    e        = ref_model(o, a, b, last_hi, last_lo);
    exp_lat  = (!o) ? W + 1 : (b == '0) ? 1 : W + 2;
    exp_busy = e.dz ? 0 : exp_lat;
    check("idle_hold_hi", hi_out, last_hi);
    check("idle_hold_lo", lo_out, last_lo);
    start = 1'b1;
    op    = o;
    a_in  = a;
    b_in  = b;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    op       = 1'($urandom);
    a_in     = $urandom;
    b_in     = $urandom;
    lat      = 0;
    busy_cnt = 0;
    seen     = 0;
    aborted  = 0;
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      if (inject && (k == 5 || k == 20)) begin
        start = 1'b1;
        op    = ~o;
        a_in  = $urandom;
        b_in  = $urandom;
      end else begin
        start = 1'b0;
      end
      if (k == abort_at) begin
        #2 reset = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_hi", hi_out, 0);
        check("abort_lo", lo_out, 0);
        void'(sb.pop_back());
        last_hi = '0;
        last_lo = '0;
        repeat (2) @(negedge clk);
        check("abort_no_done", done, 0);
        reset   = 1'b1;
        aborted = 1;
        break;
      end
      if (done) begin
        lat  = k;
        seen = 1;
        break;
      end
      if (busy) busy_cnt++;
    end
    if (!aborted) begin
      if (!seen) begin
        vectors++;
        miscompares++;
        $display("FAIL done_timeout: got no done within 100 cycles expected done after %0d", exp_lat);
        @(negedge clk);
      end else begin
        check("latency", lat, exp_lat);
        check("busy_cycles", busy_cnt, exp_busy);
        @(negedge clk);
        check("pulse_width", {done, load_hi, load_lo, div_zero}, 0);
        if (!e.dz) begin
          last_hi = e.hi;
          last_lo = e.lo;
        end
      end
    end
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    logic         ro;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_hi", hi_out, 0);
    check("reset_lo", lo_out, 0);
    check("reset_pulses", {load_hi, load_lo, div_zero}, 0);
    reset = 1'b1;
    @(negedge clk);

    do_op(1'b0, 32'hFFFF_FFFD, 32'd7, 0, -1);
    do_op(1'b1, -32'sd7, 32'd2, 0, -1);
    do_op(1'b1, 32'd7, -32'sd2, 0, -1);
    do_op(1'b0, 32'd5, 32'd6, 0, -1);
    do_op(1'b1, 32'd9, 32'd0, 0, -1);
    do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, -1);
    do_op(1'b0, 32'h8000_0000, 32'h8000_0000, 0, -1);
    do_op(1'b0, 32'd12345, -32'sd999, 1, -1);
    do_op(1'b1, -32'sd100000, 32'd37, 0, -1);
    do_op(1'b1, 32'd1000, 32'd7, 0, 10);
    do_op(1'b0, 32'd2, 32'd3, 0, -1);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: ra = 32'h8000_0000;
        2: rb = '1;
        3: begin ra = $urandom_range(0, 50); rb = $urandom_range(1, 9); end
        default: ;
      endcase
      do_op(ro, ra, rb, 0, -1);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
